// File: rtl/fpdiv_sched.sv
// Two-requester round-robin scheduler in front of one fixed-latency fpdiv unit.
// Latches operands, pulses start, times the divide, returns the result with a requester id.
module fpdiv_sched #(
    parameter int LATENCY = 12,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [31:0]      a_n,
    input  logic [31:0]      a_d,
    input  logic [1:0]       a_op,
    input  logic             a_rm,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [31:0]      b_n,
    input  logic [31:0]      b_d,
    input  logic [1:0]       b_op,
    input  logic             b_rm,
    output logic [31:0]      div_n,
    output logic [31:0]      div_d,
    output logic [1:0]       div_op,
    output logic             div_rm,
    output logic             div_start,
    input  logic [31:0]      div_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    // Counter only ever holds values up to LATENCY-1.
    localparam int LAT_W = ($clog2(LATENCY) > 0) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             ptr;       // 0 = A has priority, 1 = B
    logic [LAT_W-1:0] cnt;
    logic             accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        case (state)
            IDLE: begin
                a_ready = a_valid & (~b_valid | ~ptr);
                b_ready = b_valid & (~a_valid | ptr);
                if (a_ready | b_ready) state_nxt = LOAD;
            end
            LOAD: state_nxt = RUN;
            RUN:  if (cnt == '0) state_nxt = DONE;
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = a_ready | b_ready;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_n      <= '0;
            div_d      <= '0;
            div_op     <= '0;
            div_rm     <= 1'b0;
            div_start  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            done_count <= '0;
            ptr        <= 1'b0;
            cnt        <= '0;
        end else begin
            // Registered so the pulse lines up exactly with the LOAD cycle.
            div_start <= accept;
            if (accept) begin
                div_n  <= b_ready ? b_n  : a_n;
                div_d  <= b_ready ? b_d  : a_d;
                div_op <= b_ready ? b_op : a_op;
                div_rm <= b_ready ? b_rm : a_rm;
                rsp_id <= b_ready;
                ptr    <= ~b_ready;
            end
            if (state == LOAD) cnt <= LAT_W'(LATENCY - 1);
            if (state == RUN) begin
                if (cnt == '0) rsp_data <= div_result;
                else           cnt      <= cnt - LAT_W'(1);
            end
            if (state == DONE && rsp_ready) done_count <= done_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fpdiv_sched.sv
// Bench for fpdiv_sched: timeline-based reference model checked every cycle, plus directed literal checks.
module tb_fpdiv_sched;
    localparam int LATENCY = 12;
    localparam int CNT_W   = 2;

    logic clk = 1'b0;
    logic reset;
    logic a_valid, a_ready, a_rm, b_valid, b_ready, b_rm;
    logic [31:0] a_n, a_d, b_n, b_d;
    logic [1:0]  a_op, b_op;
    logic [31:0] div_n, div_d, div_result, rsp_data;
    logic [1:0]  div_op;
    logic div_rm, div_start, rsp_valid, rsp_ready, rsp_id, busy;
    logic [CNT_W-1:0] done_count;

    fpdiv_sched #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_n(a_n), .a_d(a_d), .a_op(a_op), .a_rm(a_rm),
        .b_valid(b_valid), .b_ready(b_ready), .b_n(b_n), .b_d(b_d), .b_op(b_op), .b_rm(b_rm),
        .div_n(div_n), .div_d(div_d), .div_op(div_op), .div_rm(div_rm),
        .div_start(div_start), .div_result(div_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] div_model(input logic [31:0] n, input logic [31:0] d,
                                              input logic [1:0] op, input logic rm);
        if (n == 32'h3F800000 && d == 32'h40000000 && op == 2'd0) return 32'h3F000000;
        return (n ^ (d << 1)) + {29'b0, op, rm};
    endfunction

    // Divider stand-in: garbage until LATENCY cycles after start falls.
    int dcnt = 0;
    always @(posedge clk) begin
        if (div_start) dcnt <= 0;
        else if (dcnt < 1000) dcnt <= dcnt + 1;
    end
    assign div_result = (dcnt >= LATENCY - 1) ? div_model(div_n, div_d, div_op, div_rm) : 32'hDEADBEEF;

    // Reference model: an operation is a timeline measured in cycles since accept.
    logic m_busy = 1'b0, m_ptr = 1'b0, m_id = 1'b0, m_rm = 1'b0;
    int   m_age = 0;
    logic [31:0] m_n = '0, m_d = '0, m_data = '0;
    logic [1:0]  m_op = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    wire m_a_rdy = !m_busy && a_valid && (!b_valid || !m_ptr);
    wire m_b_rdy = !m_busy && b_valid && (!a_valid || m_ptr);
    wire m_rsp   = m_busy && (m_age >= LATENCY + 2);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 0; m_ptr <= 0; m_id <= 0; m_age <= 0;
            m_n <= '0; m_d <= '0; m_op <= '0; m_rm <= 0; m_data <= '0; m_cnt <= '0;
        end else if (!m_busy) begin
            if (m_a_rdy || m_b_rdy) begin
                m_n    <= m_b_rdy ? b_n  : a_n;
                m_d    <= m_b_rdy ? b_d  : a_d;
                m_op   <= m_b_rdy ? b_op : a_op;
                m_rm   <= m_b_rdy ? b_rm : a_rm;
                m_id   <= m_b_rdy;
                m_ptr  <= !m_b_rdy;
                m_busy <= 1;
                m_age  <= 1;
            end
        end else if (m_rsp) begin
            if (rsp_ready) begin
                m_busy <= 0;
                m_cnt  <= m_cnt + 1'b1;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == LATENCY + 2) m_data <= div_model(m_n, m_d, m_op, m_rm);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_ready", a_ready, m_a_rdy);
            chk("b_ready", b_ready, m_b_rdy);
            chk("busy", busy, m_busy);
            chk("div_start", div_start, m_busy && m_age == 1);
            chk("rsp_valid", rsp_valid, m_rsp);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_id", rsp_id, m_id);
            chk("div_n", div_n, m_n);
            chk("div_d", div_d, m_d);
            chk("div_op", div_op, m_op);
            chk("div_rm", div_rm, m_rm);
            chk("done_count", done_count, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int cyc, got;
    logic [31:0] ids[4];
    logic [31:0] cnts[4];

    initial begin
        reset = 1; rsp_ready = 1;
        a_valid = 0; a_n = '0; a_d = '0; a_op = '0; a_rm = 0;
        b_valid = 0; b_n = '0; b_d = '0; b_op = '0; b_rm = 0;
        #2 reset = 0;
        #1 chk_on = 1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done_count, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_div_start", div_start, 0);
        step(); step();
        reset = 1;
        step();

        // A alone
        a_valid = 1; a_n = 32'h3F800000; a_d = 32'h40000000; a_op = 0; a_rm = 0;
        #1 chk("t1_a_ready", a_ready, 1);
        step();
        a_valid = 0;
        #1 chk("t1_start_c1", div_start, 1);
        chk("t1_a_ready_off", a_ready, 0);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            step(); cyc++;
            if (cyc == 2) chk("t1_start_c2", div_start, 0);
        end
        chk("t1_latency", cyc, 14);
        chk("t1_data", rsp_data, 32'h3F000000);
        chk("t1_id", rsp_id, 0);
        step();
        chk("t1_done", done_count, 1);
        chk("t1_idle", busy, 0);

        // Both valid from reset: alternate A,B,A,B; done_count wraps at 4
        reset = 0;
        step();
        reset = 1;
        a_valid = 1; a_n = 32'h40400000; a_d = 32'h3F800000; a_op = 1; a_rm = 1;
        b_valid = 1; b_n = 32'h11111111; b_d = 32'h22222222; b_op = 3; b_rm = 0;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 400) begin
            step(); cyc++;
            if (rsp_valid) begin
                ids[got] = {31'b0, rsp_id};
                cnts[got] = {30'b0, done_count};
                got++;
            end
        end
        a_valid = 0; b_valid = 0;
        chk("t2_count", got, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_id", ids[i], i % 2);
            chk("t2_cnt", cnts[i], i);
        end
        step();
        chk("t2_wrap", done_count, 0);

        // Backpressure with churning operands
        a_valid = 1; a_n = 32'h12345678; a_d = 32'h00010001; a_op = 2; a_rm = 1;
        rsp_ready = 0;
        step();
        b_valid = 1;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            a_n = $urandom; a_d = $urandom; a_op = 2'($urandom); a_rm = 1'($urandom); b_n = $urandom;
            step(); cyc++;
        end
        chk("t3_latency", cyc, 14);
        chk("t3_div_n", div_n, 32'h12345678);
        chk("t3_div_d", div_d, 32'h00010001);
        chk("t3_div_op", div_op, 2);
        chk("t3_div_rm", div_rm, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t3_data", rsp_data, 32'h1236567F);
            chk("t3_id", rsp_id, 0);
            chk("t3_a_ready", a_ready, 0);
            chk("t3_b_ready", b_ready, 0);
            chk("t3_busy", busy, 1);
            chk("t3_done", done_count, 0);
        end
        a_valid = 0; b_valid = 0; rsp_ready = 1;
        step();
        chk("t3_done_after", done_count, 1);
        chk("t3_idle", busy, 0);

        // Reset in RUN cycle 5 aborts without a response
        b_valid = 1; b_n = 32'hAAAA5555; b_d = 32'h0F0F0F0F; b_op = 1; b_rm = 0;
        step();
        b_valid = 0;
        repeat (5) step();
        chk("t4_busy_pre", busy, 1);
        reset = 0;
        #1;
        chk("t4_div_n", div_n, 0);
        chk("t4_div_d", div_d, 0);
        chk("t4_div_op", div_op, 0);
        chk("t4_div_rm", div_rm, 0);
        chk("t4_start", div_start, 0);
        chk("t4_rsp_valid", rsp_valid, 0);
        chk("t4_rsp_data", rsp_data, 0);
        chk("t4_rsp_id", rsp_id, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done_count, 0);
        step();
        reset = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_no_rsp", rsp_valid, 0);
        end
        a_valid = 1; a_n = 32'h3F800000; a_d = 32'h40000000; a_op = 0; a_rm = 0;
        step();
        a_valid = 0;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            step(); cyc++;
        end
        chk("t4_latency", cyc, 14);
        chk("t4_data", rsp_data, 32'h3F000000);
        step();
        chk("t4_done_after", done_count, 1);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fpdiv_sched.md
Name: fpdiv_sched

Overview:
- Two-requester scheduler that shares one fixed-latency fpdiv unit.
- Arbitrates round-robin, latches operands, pulses the divider start, counts the divide latency, captures the result, and returns it with a requester id over a valid/ready response channel.
- Sits between the two issue ports of the FP execute stage and a single fpdiv instance.

Parameters:
LATENCY, 12, divider cycles from start pulse deassertion to valid result (>=1)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-low reset
a_valid  in  1  requester A has an operation
a_ready  out  1  scheduler accepts A this cycle
a_n  in  32  A dividend/operand
a_d  in  32  A divisor
a_op  in  2  A operation code
a_rm  in  1  A rounding mode
b_valid  in  1  requester B has an operation
b_ready  out  1  scheduler accepts B this cycle
b_n  in  32  B dividend/operand
b_d  in  32  B divisor
b_op  in  2  B operation code
b_rm  in  1  B rounding mode
div_n  out  32  latched operand to divider
div_d  out  32  latched divisor to divider
div_op  out  2  latched op to divider
div_rm  out  1  latched rounding mode to divider
div_start  out  1  one-cycle active-high pulse, drives divider reset/start
div_result  in  32  divider result
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  32  registered result
rsp_id  out  1  0 = A, 1 = B
busy  out  1  high in any state except IDLE
done_count  out  CNT_W  completed responses, wraps

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Reset (reset=0, async) forces IDLE.
- Reset values: div_n/div_d/rsp_data=0, div_op=0, div_rm=0, div_start=0, rsp_valid=0, rsp_id=0, done_count=0, priority pointer=A.
- Reset mid-operation aborts the operation with no response. All registers return to reset values.
- a_ready/b_ready are combinational and are asserted only in IDLE.
  - Only one is high at a time: the single valid requester, or the pointer's requester when both are valid.
  - Both are 0 in any other state.
- Accept (IDLE, x_valid & x_ready):
  - Latch n/d/op/rm into div_* and the id into rsp_id.
  - Flip the pointer to the other requester.
  - Go to LOAD.
- LOAD lasts one cycle. div_start=1 only in LOAD. The counter loads LATENCY-1. Go to RUN.
- RUN: the counter decrements each cycle. When counter==0, register div_result into rsp_data and go to DONE.
- DONE: rsp_valid=1. rsp_data and rsp_id hold stable while rsp_ready=0. On rsp_ready: increment done_count (mod 2^CNT_W) and go to IDLE.
- Latency: accept at edge 0 gives rsp_valid high from cycle LATENCY+2, i.e. 14 cycles for the default.
- Minimum issue interval is LATENCY+3 cycles because a new request is accepted only in IDLE.
- div_* hold their values from accept until the next accept, so operands stay stable throughout RUN.
- Requester inputs are ignored outside IDLE. A requester that drops valid while not granted loses nothing.
- Pointer rule: the pointer updates only on accept. A lone requester is granted regardless of the pointer.
- busy = (state != IDLE).

Test Plan:
- Reset, then A only: a_n=0x3F800000, a_d=0x40000000, a_op=0; divider model returns 0x3F000000 → a_ready=1 for one cycle; div_start pulses cycle 1 only; rsp_valid at cycle 14 with rsp_data=0x3F000000, rsp_id=0; done_count=1 after rsp_ready.
- A and B both valid at reset (pointer=A) → A granted first (rsp_id=0); B granted on the next IDLE (rsp_id=1); with both held valid, grants alternate A,B,A,B over 4 operations.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid → rsp_data/rsp_id stable; a_ready=b_ready=0; busy=1; done_count unchanged until rsp_ready=1.
- Operand stability: change a_n/a_d every cycle during RUN → div_n/div_d stay equal to the accepted values; div_op/div_rm are unchanged.
- Assert reset=0 in RUN cycle 5 → all outputs are 0 immediately; state IDLE; no rsp_valid after release; next request completes normally.
- done_count wrap: preset via 2^CNT_W completions (or CNT_W=2 build, 4 ops) → count returns to 0.
